axis_stream2bram_slave: RTL and testbench
=========================================

Name: axis_stream2bram_slave

Overview:
AXI4-Stream slave that deserializes one frame of beats into a BRAM write port, word N of the frame going to address N. It is the receive-side counterpart of our BRAM-to-stream master and sits between the DMA/stream interconnect and a simple-dual-port BRAM. It checks frame length against DST_ADDR_MAX and flags early-TLAST and overrun frames. It pulses done once the final write has been issued.

Parameters:
C_S_AXIS_TDATA_WIDTH, 32, stream and BRAM data width; multiple of 8.
DST_ADDR_WIDTH, 12, BRAM address width.
DST_ADDR_MAX, 1024, expected words per frame; must be >= 2 and <= 2^DST_ADDR_WIDTH.

Ports:
S_AXIS_ACLK  in  1  clock
S_AXIS_ARESET  in  1  asynchronous active-high reset
S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  beat data
S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte qualifiers
S_AXIS_TLAST  in  1  frame end marker
S_AXIS_TVALID  in  1  beat valid
S_AXIS_TREADY  out  1  slave ready
dst_ready  in  1  BRAM free; arms reception of the next frame
dst_addr  out  DST_ADDR_WIDTH  BRAM write address
dst_data  out  C_S_AXIS_TDATA_WIDTH  BRAM write data
dst_we  out  C_S_AXIS_TDATA_WIDTH/8  per-byte write enable
dst_enable  out  1  BRAM port enable
word_count  out  DST_ADDR_WIDTH+1  words written in last/current frame
err_early_last  out  1  TLAST seen before DST_ADDR_MAX words
err_overrun  out  1  DST_ADDR_MAX words seen without TLAST
done  out  1  one-cycle frame-complete pulse

Behaviour:
- Clock is S_AXIS_ACLK, single domain. Reset S_AXIS_ARESET is asynchronous and active-high.
- Reset, applied at any time including mid-frame, immediately forces:
  - state WAIT
  - TREADY=0, dst_we=0, dst_addr=0, dst_data=0
  - word_count=0, both errors 0, done=0
- dst_enable is tied to 1.
- All outputs are registered.
- Handshake: a beat is accepted when TVALID && TREADY on a rising edge.
- States:
  - WAIT:
    - TREADY=0.
    - When dst_ready=1, go to RECV.
    - On that transition, clear word_count, err_early_last and err_overrun, and zero the internal address counter.
  - RECV:
    - TREADY=1.
    - Each handshake registers dst_addr=counter, dst_data=TDATA and dst_we=TSTRB; these appear the next cycle for exactly one cycle.
    - Each handshake increments counter and word_count.
    - A beat with TSTRB=0 still counts and still advances the address, but dst_we=0.
  - FLUSH:
    - TREADY=0, one cycle.
    - The final write strobe is on the port during this cycle.
    - Go to DONE.
  - DRAIN:
    - TREADY=1.
    - Beats are accepted and discarded: no dst_we, no count change.
    - On the handshake with TLAST, go to DONE.
  - DONE:
    - done=1 for exactly one cycle, TREADY=0.
    - Go to WAIT.
- RECV exit rules, evaluated on a handshake with counter value c (0-based):
  - TLAST=1 and c==DST_ADDR_MAX-1: normal end, go to FLUSH.
  - TLAST=1 and c<DST_ADDR_MAX-1: set err_early_last, go to FLUSH. The beat is still written.
  - TLAST=0 and c==DST_ADDR_MAX-1: set err_overrun, go to DRAIN. The beat is still written.
- Addresses never wrap: the maximum dst_addr is DST_ADDR_MAX-1.
- Latency:
  - Handshake at cycle N gives dst_we at N+1.
  - For the final beat, done is at N+2 (FLUSH then DONE), or at N+1 after the TLAST handshake in DRAIN.
- TREADY is independent of TVALID, so there is no combinational input-to-output path.
- word_count and the error flags hold their values after done until the next WAIT→RECV transition.
- dst_ready is sampled only in WAIT. Dropping it during RECV has no effect.
- If dst_ready is held high, consecutive frames are accepted with 3 idle TREADY=0 cycles between them (FLUSH, DONE, WAIT).
- Throughput in RECV is 1 beat/cycle with TVALID held high. Bubbles on TVALID are tolerated with no state change.

Test Plan:
- Parameters for all scenarios: WIDTH=32, DST_ADDR_MAX=8.
- Normal frame: dst_ready=1, 8 back-to-back beats with data 0x100+i and TLAST on beat 7.
  - Expect writes to addr 0..7 with those data and dst_we=0xF.
  - Expect done 2 cycles after beat 7, word_count=8, no errors.
- Gapped stream: same frame with TVALID toggling 1/0.
  - Expect identical writes, each dst_we exactly 1 cycle after its handshake, and no duplicate writes.
- Early TLAST: 5 beats with TLAST on beat 4.
  - Expect writes to addr 0..4, err_early_last=1, word_count=5, done pulse.
  - Errors clear when the next frame starts.
- Overrun: 11 beats with TLAST on beat 10.
  - Expect writes only to addr 0..7, err_overrun=1, beats 8..10 accepted with no dst_we.
  - Expect done 1 cycle after the beat-10 handshake, word_count=8.
- Byte strobes: beat 2 with TSTRB=0x5 and beat 3 with TSTRB=0.
  - Expect dst_we=0x5 at addr 2, and dst_we=0 at the cycle for addr 3.
  - Expect word_count=8 and later beats at addr 4..7.
- Async reset mid-frame: assert S_AXIS_ARESET between clock edges after beat 3.
  - Expect TREADY, dst_we and word_count at 0 immediately, with no done.
  - After release and dst_ready=1, a fresh frame writes from addr 0.

Source files
------------

// File: rtl/axis_stream2bram_slave.sv
// rtl/axis_stream2bram_slave.sv - AXI4-Stream slave that writes one frame of beats into a BRAM write port
module axis_stream2bram_slave #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int DST_ADDR_WIDTH       = 12,
    parameter int DST_ADDR_MAX         = 1024
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESET,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    input  logic                                dst_ready,
    output logic [DST_ADDR_WIDTH-1:0]           dst_addr,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]     dst_data,
    output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   dst_we,
    output logic                                dst_enable,
    output logic [DST_ADDR_WIDTH:0]             word_count,
    output logic                                err_early_last,
    output logic                                err_overrun,
    output logic                                done
);

    // Address of the last word of a well-formed frame; the counter never writes past it.
    localparam logic [DST_ADDR_WIDTH-1:0] LAST_ADDR = DST_ADDR_WIDTH'(DST_ADDR_MAX - 1);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_RECV,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [DST_ADDR_WIDTH-1:0] addr_cnt;
    logic                      hs;
    logic                      at_last_addr;
    logic                      start;

    // The BRAM port is permanently enabled; writes are qualified by dst_we alone.
    assign dst_enable   = 1'b1;

    // TREADY is a registered function of state, so this handshake has no comb path to outputs.
    assign hs           = S_AXIS_TVALID && S_AXIS_TREADY;
    assign at_last_addr = (addr_cnt == LAST_ADDR);
    assign start        = (state == ST_WAIT) && dst_ready;

    // State register.
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: frame ends on TLAST, or switches to draining once the BRAM is full.
    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT: begin
                if (dst_ready) begin
                    state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                if (hs) begin
                    if (S_AXIS_TLAST) begin
                        state_next = ST_FLUSH;
                    end else if (at_last_addr) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_FLUSH: state_next = ST_DONE;
            ST_DRAIN: begin
                if (hs && S_AXIS_TLAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_WAIT;
            default:  state_next = ST_WAIT;
        endcase
    end

    // Registered outputs: write port, handshake ready, counters, error flags and done pulse.
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            S_AXIS_TREADY  <= 1'b0;
            done           <= 1'b0;
            dst_addr       <= '0;
            dst_data       <= '0;
            dst_we         <= '0;
            addr_cnt       <= '0;
            word_count     <= '0;
            err_early_last <= 1'b0;
            err_overrun    <= 1'b0;
        end else begin
            S_AXIS_TREADY <= (state_next == ST_RECV) || (state_next == ST_DRAIN);
            done          <= (state_next == ST_DONE);
            // Write strobe lives for exactly one cycle per accepted beat.
            dst_we        <= '0;
            if (start) begin
                addr_cnt       <= '0;
                word_count     <= '0;
                err_early_last <= 1'b0;
                err_overrun    <= 1'b0;
            end else if ((state == ST_RECV) && hs) begin
                dst_addr   <= addr_cnt;
                dst_data   <= S_AXIS_TDATA;
                dst_we     <= S_AXIS_TSTRB;
                // The counter may wrap after the last address, but RECV is always left on that beat.
                addr_cnt   <= addr_cnt + 1'b1;
                word_count <= word_count + 1'b1;
                if (S_AXIS_TLAST && !at_last_addr) begin
                    err_early_last <= 1'b1;
                end
                if (!S_AXIS_TLAST && at_last_addr) begin
                    err_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_stream2bram_slave.sv
// tb/tb_axis_stream2bram_slave.sv - self-checking bench for axis_stream2bram_slave
module tb_axis_stream2bram_slave;

    localparam int W   = 32;
    localparam int AW  = 3;
    localparam int MAX = 8;
    localparam int SW  = W / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  tdata = '0;
    logic [SW-1:0] tstrb = '0;
    logic          tlast = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic          dst_ready = 1'b0;
    logic [AW-1:0] dst_addr;
    logic [W-1:0]  dst_data;
    logic [SW-1:0] dst_we;
    logic          dst_enable;
    logic [AW:0]   word_count;
    logic          err_early_last;
    logic          err_overrun;
    logic          done;

    axis_stream2bram_slave #(
        .C_S_AXIS_TDATA_WIDTH(W),
        .DST_ADDR_WIDTH(AW),
        .DST_ADDR_MAX(MAX)
    ) dut (
        .S_AXIS_ACLK(clk),
        .S_AXIS_ARESET(rst),
        .S_AXIS_TDATA(tdata),
        .S_AXIS_TSTRB(tstrb),
        .S_AXIS_TLAST(tlast),
        .S_AXIS_TVALID(tvalid),
        .S_AXIS_TREADY(tready),
        .dst_ready(dst_ready),
        .dst_addr(dst_addr),
        .dst_data(dst_data),
        .dst_we(dst_we),
        .dst_enable(dst_enable),
        .word_count(word_count),
        .err_early_last(err_early_last),
        .err_overrun(err_overrun),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  data;
        logic [SW-1:0] strb;
        bit            last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [SW-1:0] we;
        time           t;
    } wr_t;

    typedef struct {
        int            n;
        int            gaps;
        int            a_idx;
        logic [SW-1:0] a_strb;
        int            b_idx;
        logic [SW-1:0] b_strb;
        int            exp_wc;
        bit            exp_e;
        bit            exp_o;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    string tag = "init";

    beat_t fr[$];
    time   hs_t[$];
    wr_t   wr_q[$];
    int    exp_idx[$];
    int    m_wc;
    bit    m_e;
    bit    m_o;
    time   m_dly;
    int    done_cnt = 0;
    time   done_time = 0;

    // Observe the BRAM port and done pulse half a cycle after each edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (dst_we != '0) wr_q.push_back('{dst_addr, dst_data, dst_we, $time});
            if (done === 1'b1) begin
                done_cnt++;
                done_time = $time;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h expected=%0h", tag, name, act, exp);
        end
    endtask

    // Frame-level reference: a frame fills at most MAX words; short frames are early, long ones overrun.
    task automatic model();
        int n;
        n = fr.size();
        exp_idx.delete();
        if (n <= MAX) begin
            m_wc  = n;
            m_e   = (n < MAX);
            m_o   = 1'b0;
            m_dly = 15;
        end else begin
            m_wc  = MAX;
            m_e   = 1'b0;
            m_o   = 1'b1;
            m_dly = 5;
        end
        for (int i = 0; i < m_wc; i++) begin
            if (fr[i].strb != '0) exp_idx.push_back(i);
        end
    endtask

    // gaps: 0 = back-to-back, 1 = bubble before every beat, 2 = random bubbles.
    task automatic send_beats(input int gaps, input bit drop_ready, output bit ok);
        int budget;
        bit first;
        first = 1'b1;
        ok    = 1'b1;
        hs_t.delete();
        for (int i = 0; i < fr.size(); i++) begin
            if (i > 0 && (gaps == 1 || (gaps == 2 && $urandom_range(0, 1) == 1))) begin
                @(negedge clk);
                tvalid = 1'b0;
                @(posedge clk);
            end
            @(negedge clk);
            tvalid = 1'b1;
            tdata  = fr[i].data;
            tstrb  = fr[i].strb;
            tlast  = fr[i].last;
            budget = 0;
            while (!tready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (!tready) begin
                check("tready_timeout", 64'd0, 64'd1);
                tvalid = 1'b0;
                ok = 1'b0;
                return;
            end
            if (first) begin
                check("start_word_count", word_count, 0);
                check("start_err_early", err_early_last, 0);
                check("start_err_overrun", err_overrun, 0);
                if (drop_ready) dst_ready = 1'b0;
                first = 1'b0;
            end
            @(posedge clk);
            hs_t.push_back($time);
        end
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic run_frame(input int gaps, input bit use_tab, input int t_wc, input bit t_e, input bit t_o);
        bit ok;
        int budget;
        int base;
        model();
        if (use_tab) begin
            m_wc = t_wc;
            m_e  = t_e;
            m_o  = t_o;
        end
        wr_q.delete();
        base = done_cnt;
        @(negedge clk);
        dst_ready = 1'b1;
        send_beats(gaps, 1'b1, ok);
        if (!ok) return;
        budget = 0;
        while (done_cnt == base && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("done_seen", done_cnt > base, 1);
        check("done_latency", done_time - hs_t[hs_t.size()-1], m_dly);
        @(negedge clk);
        @(negedge clk);
        check("done_single", done_cnt - base, 1);
        check("word_count", word_count, m_wc);
        check("err_early_last", err_early_last, m_e);
        check("err_overrun", err_overrun, m_o);
        check("tready_idle", tready, 0);
        check("write_count", wr_q.size(), exp_idx.size());
        for (int k = 0; k < exp_idx.size() && k < wr_q.size(); k++) begin
            int j;
            j = exp_idx[k];
            check("wr_addr", wr_q[k].addr, j);
            check("wr_data", wr_q[k].data, fr[j].data);
            check("wr_we", wr_q[k].we, fr[j].strb);
            check("wr_time", wr_q[k].t, hs_t[j] + 5);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[8];
        bit   ok;
        bit   ok2;
        int   base;
        int   budget;
        time  t1;
        int   r;

        vecs[0] = '{8,  0, -1, 4'h0, -1, 4'h0, 8, 1'b0, 1'b0};
        vecs[1] = '{8,  1, -1, 4'h0, -1, 4'h0, 8, 1'b0, 1'b0};
        vecs[2] = '{5,  0, -1, 4'h0, -1, 4'h0, 5, 1'b1, 1'b0};
        vecs[3] = '{11, 0, -1, 4'h0, -1, 4'h0, 8, 1'b0, 1'b1};
        vecs[4] = '{8,  0,  2, 4'h5,  3, 4'h0, 8, 1'b0, 1'b0};
        vecs[5] = '{1,  0, -1, 4'h0, -1, 4'h0, 1, 1'b1, 1'b0};
        vecs[6] = '{9,  2, -1, 4'h0, -1, 4'h0, 8, 1'b0, 1'b1};
        vecs[7] = '{7,  2,  0, 4'h0,  6, 4'h8, 7, 1'b1, 1'b0};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        tag = "reset";
        check("tready", tready, 0);
        check("dst_we", dst_we, 0);
        check("dst_addr", dst_addr, 0);
        check("dst_data", dst_data, 0);
        check("word_count", word_count, 0);
        check("err_early_last", err_early_last, 0);
        check("err_overrun", err_overrun, 0);
        check("done", done, 0);
        check("dst_enable", dst_enable, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            fr.delete();
            for (int i = 0; i < vecs[v].n; i++) begin
                logic [SW-1:0] s;
                s = 4'hF;
                if (i == vecs[v].a_idx) s = vecs[v].a_strb;
                if (i == vecs[v].b_idx) s = vecs[v].b_strb;
                fr.push_back('{32'h100 + i, s, (i == vecs[v].n - 1)});
            end
            tag = $sformatf("vec%0d", v);
            run_frame(vecs[v].gaps, 1'b1, vecs[v].exp_wc, vecs[v].exp_e, vecs[v].exp_o);
        end

        tag = "reset_mid";
        fr.delete();
        for (int i = 0; i < 4; i++) fr.push_back('{32'h300 + i, 4'hF, 1'b0});
        base = done_cnt;
        @(negedge clk);
        dst_ready = 1'b1;
        send_beats(0, 1'b1, ok);
        if (ok) begin
            check("pre_we", dst_we, 4'hF);
            check("pre_addr", dst_addr, 3);
            check("pre_word_count", word_count, 4);
        end
        #2 rst = 1'b1;
        #1;
        check("tready", tready, 0);
        check("dst_we", dst_we, 0);
        check("word_count", word_count, 0);
        check("dst_addr", dst_addr, 0);
        check("done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("no_done", done_cnt - base, 0);
        check("tready_wait", tready, 0);
        fr.delete();
        for (int i = 0; i < MAX; i++) fr.push_back('{32'h400 + i, 4'hF, (i == MAX - 1)});
        tag = "after_reset";
        run_frame(0, 1'b0, 0, 1'b0, 1'b0);

        tag = "b2b";
        fr.delete();
        for (int i = 0; i < MAX; i++) fr.push_back('{32'h500 + i, 4'hF, (i == MAX - 1)});
        wr_q.delete();
        base = done_cnt;
        @(negedge clk);
        dst_ready = 1'b1;
        send_beats(0, 1'b0, ok);
        t1 = ok ? hs_t[MAX-1] : 0;
        send_beats(0, 1'b1, ok2);
        if (ok && ok2) begin
            check("frame_gap", hs_t[0] - t1, 40);
            budget = 0;
            while (done_cnt < base + 2 && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            check("done_count", done_cnt - base, 2);
            check("write_count", wr_q.size(), 2 * MAX);
        end
        repeat (3) @(negedge clk);

        for (int f = 0; f < 20; f++) begin
            int n;
            n = $urandom_range(1, 12);
            fr.delete();
            for (int i = 0; i < n; i++) begin
                logic [SW-1:0] s;
                r = $urandom_range(0, 3);
                s = (r == 0) ? 4'h0 : ((r == 1) ? 4'($urandom_range(1, 15)) : 4'hF);
                fr.push_back('{$urandom, s, (i == n - 1)});
            end
            tag = $sformatf("rand%0d", f);
            run_frame(2, 1'b0, 0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
